// File: rtl/spi_ram_pkg.sv
// Shared types and helpers for the burst-capable SPI command RAM.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD_WAIT
  } state_e;

  function automatic int unsigned pay_w(input int unsigned addr_size,
                                        input int unsigned mem_width);
    return (addr_size > mem_width) ? addr_size : mem_width;
  endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave (master side) and the RAM (slave side).
interface spi_ram_burst_if #(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 8
);
  localparam int unsigned CMD_W = 2 + spi_ram_pkg::pay_w(ADDR_SIZE, MEM_WIDTH);

  logic                 rx_valid;
  logic [CMD_W-1:0]     din;
  logic                 tx_ack;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;
  logic                 busy;
  logic                 cmd_err;

  modport master (
    output rx_valid, din, tx_ack,
    input  dout, tx_valid, busy, cmd_err
  );

  modport slave (
    input  rx_valid, din, tx_ack,
    output dout, tx_valid, busy, cmd_err
  );
endinterface

// File: rtl/spi_ram_mem.sv
// Single-port array, synchronous write and synchronous read; read data holds when idle.
module spi_ram_mem #(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder and read handshake for the SPI RAM, with post-reset clear and burst
// auto-increment.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_burst_if.slave  bus
);

  localparam int unsigned PAY_W = pay_w(ADDR_SIZE, MEM_WIDTH);
  localparam int unsigned CMD_W = 2 + PAY_W;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
  logic                 cmd_err_q, cmd_err_d;

  logic                 mem_we, mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [MEM_WIDTH-1:0] mem_wdata, mem_rdata;

  opcode_e              op;
  logic [PAY_W-1:0]     payload;
  logic [ADDR_SIZE-1:0] pay_addr;
  logic                 addr_ok;
  logic                 take;

  assign op       = opcode_e'(bus.din[CMD_W-1 -: 2]);
  assign payload  = bus.din[PAY_W-1:0];
  assign pay_addr = payload[ADDR_SIZE-1:0];
  assign addr_ok  = ({1'b0, pay_addr} < DEPTH_EXT);
  assign take     = (state_q == RD_WAIT) && bus.tx_ack;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      clr_addr_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      clr_addr_q <= clr_addr_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    clr_addr_d = clr_addr_q;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = rd_addr_q;
    mem_wdata  = payload[MEM_WIDTH-1:0];

    unique case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = next_addr(clr_addr_q);
        cmd_err_d  = bus.rx_valid;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE, RD_WAIT: begin
        if (take) begin
          state_d = IDLE;
        end
        if (bus.rx_valid) begin
          unique case (op)
            OP_WR_ADDR: begin
              if (addr_ok) wr_addr_d = pay_addr;
              else         cmd_err_d = 1'b1;
            end
            OP_WR_DATA: begin
              mem_we   = 1'b1;
              mem_addr = wr_addr_q;
              if (AUTO_INC) wr_addr_d = next_addr(wr_addr_q);
            end
            OP_RD_ADDR: begin
              if (addr_ok) rd_addr_d = pay_addr;
              else         cmd_err_d = 1'b1;
            end
            OP_RD_DATA: begin
              // A read while the previous word is still unacknowledged would clobber dout.
              if ((state_q == IDLE) || take) begin
                mem_re  = 1'b1;
                state_d = RD_WAIT;
                if (AUTO_INC) rd_addr_d = next_addr(rd_addr_q);
              end else begin
                cmd_err_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = INIT;
    endcase
  end

  spi_ram_mem #(
    .MEM_WIDTH(MEM_WIDTH),
    .ADDR_SIZE(ADDR_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // tx_valid is exactly the RD_WAIT state; dout is masked so reset forces it to zero.
  assign bus.tx_valid = (state_q == RD_WAIT);
  assign bus.dout     = bus.tx_valid ? mem_rdata : '0;
  assign bus.busy     = (state_q == INIT);
  assign bus.cmd_err  = cmd_err_q;

endmodule
